// File: rtl/seq_det_param.sv
// seq_det_param: serial pattern detector with a runtime-loadable pattern of
// 1..MAX_LEN bits, selectable overlapping / non-overlapping detection and a
// Mealy match pulse z. The reset pattern is 1100, length 4, so MAX_LEN must be
// at least 4 when the reset pattern is relied upon.
// Optional saturating match counter: define SEQ_DET_CNT_EN.
module seq_det_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_vld,
  input  logic               overlap,
  input  logic               pat_ld,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LW-1:0]      len_in,
  output logic               z
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] lenMask;
  logic               lenInOk;
  logic               fillOk;
  logic               patEq;
  logic               zInt;

  // Match decode: the stored history with the incoming bit appended is
  // compared against the pattern, only over the low len_q bits, and only once
  // enough bits have been collected since the last clear.
  always_comb begin
    lenMask = '0;
    window  = {hist_q, x};
    for (int i = 0; i < MAX_LEN; i++) begin
      lenMask[i] = (i < int'(len_q));
    end
    fillOk = (fill_q >= (len_q - 1'b1));
    patEq  = (((window ^ pat_q) & lenMask) == '0);
    zInt   = reset && x_vld && !pat_ld && fillOk && patEq;
  end

  assign z = zInt;

  // Next state: a load strobe owns the cycle (its bit is dropped even when
  // the load is rejected); otherwise a valid bit shifts into the history,
  // except that a non-overlapping match restarts the fill from zero.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    lenInOk = (len_in != '0) && (len_in <= LW'(MAX_LEN));
    if (pat_ld) begin
      if (lenInOk) begin
        pat_d  = pat_in;
        len_d  = len_in;
        fill_d = '0;
      end
    end else if (x_vld) begin
      if (zInt && !overlap) begin
        fill_d = '0;
      end else begin
        hist_d = window[MAX_LEN-2:0];
        if (fill_q != LW'(MAX_LEN)) begin
          fill_d = fill_q + 1'b1;
        end
      end
    end
  end

  // State registers; synchronous active-low reset restores the 1100 pattern.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q  <= MAX_LEN'(4'b1100);
      len_q  <= LW'(4);
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Match counter: saturating increment on each pulse, cleared by an
  // accepted pattern load.
  always_comb begin
    cnt_d = cnt_q;
    if (pat_ld) begin
      if (lenInOk) begin
        cnt_d = '0;
      end
    end else if (zInt && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic [31:0] unusedCntW;
  assign unusedCntW = 32'(CNT_W);
`endif

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits, range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-low; sampled on the rising edge of clk.
REQ-005 Port x, input, 1: serial data bit.
REQ-006 Port x_vld, input, 1: x is consumed only in cycles with x_vld=1.
REQ-007 Port overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
REQ-008 Port pat_ld, input, 1: single-cycle strobe to load a new pattern.
REQ-009 Port pat_in, input, MAX_LEN: new pattern; pat_in[len_in-1] is the first bit received, pat_in[0] the last.
REQ-010 Port len_in, input, clog2(MAX_LEN+1): new pattern length.
REQ-011 Port z, output, 1: Mealy match pulse, combinational from state, x, x_vld.
REQ-012 Port match_cnt, output, CNT_W: registered count of matches; present only with SEQ_DET_CNT_EN.

Function
REQ-013 Block SHALL hold registers: pattern pat_q[MAX_LEN], length len_q, history hist_q[MAX_LEN-1], fill counter fill_q saturating at MAX_LEN.
REQ-014 z SHALL be 1 iff x_vld=1, pat_ld=0, fill_q >= len_q-1, and {hist_q[len_q-2:0], x} == pat_q[len_q-1:0]; zero-latency with the completing bit.
REQ-015 On a consumed bit with no match: hist_q shifts left taking x into bit 0; fill_q increments (saturating).
REQ-016 On a match with overlap=1: behave as REQ-015, so a suffix of the pattern can start the next match.
REQ-017 On a match with overlap=0: fill_q SHALL clear to 0; no bit of the matched sequence contributes to a later match.
REQ-018 Cycles with x_vld=0 SHALL not change hist_q or fill_q; the value of x is ignored.
REQ-019 pat_ld=1 with 1 <= len_in <= MAX_LEN SHALL load pat_q and len_q, clear fill_q, and clear match_cnt.
REQ-020 pat_ld=1 with len_in=0 or len_in > MAX_LEN SHALL be rejected: no register changes.
REQ-021 pat_ld and x_vld in the same cycle: load has priority; that x bit SHALL be dropped and z=0, even if the load is rejected.
REQ-022 pat_in bits at or above len_q SHALL be ignored in comparison.
REQ-023 With the reset pattern and overlap=0, the z sequence SHALL be identical to the existing 1100 non-overlapping detector for any bit stream (e.g. 11100 matches on the 5th bit).

Reset
REQ-024 With reset=0 at a clk edge: pat_q=...0001100 (pattern 1100), len_q=4, hist_q=0, fill_q=0, match_cnt=0.
REQ-025 z SHALL be 0 in any cycle where reset=0, regardless of x/x_vld.
REQ-026 Reset asserted mid-sequence SHALL discard partial progress; detection restarts from the first valid bit after release.

Configuration
REQ-027 Macro SEQ_DET_CNT_EN defined: match_cnt port and counter present; it increments by 1 on each cycle with z=1, saturates at 2^CNT_W-1, clears on reset and on accepted pat_ld.
REQ-028 Macro SEQ_DET_CNT_EN undefined: no match_cnt port, no counter logic; all other behaviour unchanged.

Verification
REQ-029 After reset, overlap=0, stream 1,1,0,0,1,1,0,0 (x_vld=1) -> z=1 on bits 4 and 8 only; stream 1,1,1,0,0 -> z=1 on bit 5.
REQ-030 Load pat_in=101, len_in=3; stream 1,0,1,0,1: overlap=1 -> z on bits 3 and 5; overlap=0 -> z on bit 3 only.
REQ-031 Default pattern, x_vld pattern 1,0,1,0,1,0,1 carrying 1,X,1,X,0,X,0 -> single z pulse on the final valid bit; X values with x_vld=0 ignored.
REQ-032 pat_ld=1 in the cycle the 4th bit of 1100 arrives -> z=0, fill cleared; pat_ld with len_in=0 -> pattern 1100 retained, next 1100 matches.
REQ-033 With SEQ_DET_CNT_EN, CNT_W=2: five non-overlapping 1100 matches -> match_cnt 1,2,3,3,3; reset=0 mid-stream -> match_cnt=0, z=0, partial 11 forgotten.
